// File: rtl/fc_event_pkg.sv
// Shared constants and types for the fabric-controller event collector.
// The ID map gives the first event ID of each standard peripheral group.
package fc_event_pkg;

  localparam int unsigned NbEventsDefault = 32;
  localparam int unsigned EventIdWidth    = 8;

  typedef logic [EventIdWidth-1:0] event_id_t;

  typedef struct packed {
    event_id_t udma;
    event_id_t timer;
    event_id_t gpio;
    event_id_t hwpe;
  } id_map_t;

  localparam id_map_t IdMap = '{udma: 8'd0, timer: 8'd10, gpio: 8'd12, hwpe: 8'd14};

  // Pointer width that stays legal for a single source.
  function automatic int unsigned ptr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_event_rr_arb.sv
// Combinational round-robin find-first: lowest requesting index at or above
// ptr_i, falling back to the lowest requesting index overall (wrap-around).
module fc_event_rr_arb
  import fc_event_pkg::*;
#(
  parameter int unsigned N = NbEventsDefault,
  localparam int unsigned PtrW = ptr_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [PtrW-1:0] idx_o,
  output logic            any_o
);

  int unsigned ptr_ext;
  logic            hi_found;
  logic            lo_found;
  logic [PtrW-1:0] hi_idx;
  logic [PtrW-1:0] lo_idx;

  always_comb begin
    ptr_ext  = 32'(ptr_i);
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan: the last hit written is the lowest qualifying index.
    for (int unsigned i = N; i > 0; i--) begin
      if (req_i[i-1]) begin
        lo_found = 1'b1;
        lo_idx   = PtrW'(i - 1);
        if ((i - 1) >= ptr_ext) begin
          hi_found = 1'b1;
          hi_idx   = PtrW'(i - 1);
        end
      end
    end
    any_o   = lo_found;
    idx_o   = hi_found ? hi_idx : lo_idx;
    grant_o = '0;
    if (lo_found) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fc_event_collector.sv
// Collects event pulses into per-source pending bits and serialises them as
// IDs into the FC event FIFO; counts events coalesced into an already-pending bit.
module fc_event_collector
  import fc_event_pkg::*;
#(
  parameter int unsigned NB_EVENTS      = NbEventsDefault,
  parameter int unsigned EVENT_ID_WIDTH = EventIdWidth,
  parameter int unsigned ID_BASE        = 0,
  parameter int unsigned LOST_CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NB_EVENTS-1:0]      events_i,
  input  logic [NB_EVENTS-1:0]      event_mask_i,
  output logic                      event_fifo_valid_o,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
  input  logic                      event_fifo_fulln_i,
  output logic [NB_EVENTS-1:0]      pending_o,
  output logic                      lost_evt_o,
  output logic [LOST_CNT_WIDTH-1:0] lost_cnt_o,
  input  logic                      lost_clr_i
);

  localparam int unsigned PtrW = ptr_width(NB_EVENTS);

  if (NB_EVENTS < 1 ||
      (64'(ID_BASE) + 64'(NB_EVENTS)) > (64'd1 << EVENT_ID_WIDTH)) begin : gen_param_err
    $fatal(1, "fc_event_collector: event IDs do not fit in EVENT_ID_WIDTH");
  end

  logic [NB_EVENTS-1:0]      pending_q, pending_d;
  logic [PtrW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                      valid_q, valid_d;
  logic [EVENT_ID_WIDTH-1:0] data_q, data_d;
  logic                      lost_evt_q, lost_evt_d;
  logic [LOST_CNT_WIDTH-1:0] lost_cnt_q, lost_cnt_d;

  logic [NB_EVENTS-1:0] in_ev, arb_grant, grant, lost;
  logic [PtrW-1:0]      arb_idx;
  logic                 arb_any, can_load;

  fc_event_rr_arb #(
    .N (NB_EVENTS)
  ) u_arb (
    .req_i   (pending_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    in_ev      = events_i & ~event_mask_i;
    can_load   = ~valid_q | event_fifo_fulln_i;
    grant      = can_load ? arb_grant : '0;
    lost       = in_ev & pending_q & ~grant;
    // A grant and a new event on the same bit re-arm it without loss.
    pending_d  = (pending_q & ~grant) | in_ev;
    lost_evt_d = |lost;
    rr_ptr_d   = rr_ptr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    if (can_load) begin
      valid_d = arb_any;
      if (arb_any) begin
        data_d   = EVENT_ID_WIDTH'(ID_BASE + 32'(arb_idx));
        rr_ptr_d = (32'(arb_idx) == NB_EVENTS - 1) ? '0 : arb_idx + 1'b1;
      end
    end
    lost_cnt_d = lost_cnt_q;
    if (lost_clr_i) begin
      lost_cnt_d = '0;
    end else if (lost_evt_d && (lost_cnt_q != '1)) begin
      lost_cnt_d = lost_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      lost_evt_q <= 1'b0;
      lost_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      lost_evt_q <= lost_evt_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign event_fifo_valid_o = valid_q;
  assign event_fifo_data_o  = data_q;
  assign pending_o          = pending_q;
  assign lost_evt_o         = lost_evt_q;
  assign lost_cnt_o         = lost_cnt_q;

endmodule

// File: tb/tb_fc_event_collector.sv
// Directed bench for fc_event_collector: expected IDs go into per-DUT queues,
// monitors pop and compare on every FIFO transfer.
module tb_fc_event_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] events, mask;
  logic        fulln, lost_clr;
  logic        valid, lost_evt;
  logic [7:0]  data;
  logic [31:0] pending;
  logic [15:0] lost_cnt;

  logic [31:0] events2;
  logic        fulln2, lost_clr2;
  logic        valid2, lost_evt2;
  logic [7:0]  data2;
  logic [31:0] pending2;
  logic [3:0]  lost_cnt2;

  fc_event_collector dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .events_i           (events),
    .event_mask_i       (mask),
    .event_fifo_valid_o (valid),
    .event_fifo_data_o  (data),
    .event_fifo_fulln_i (fulln),
    .pending_o          (pending),
    .lost_evt_o         (lost_evt),
    .lost_cnt_o         (lost_cnt),
    .lost_clr_i         (lost_clr)
  );

  fc_event_collector #(
    .ID_BASE        (16),
    .LOST_CNT_WIDTH (4)
  ) dut2 (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .events_i           (events2),
    .event_mask_i       (32'h0),
    .event_fifo_valid_o (valid2),
    .event_fifo_data_o  (data2),
    .event_fifo_fulln_i (fulln2),
    .pending_o          (pending2),
    .lost_evt_o         (lost_evt2),
    .lost_cnt_o         (lost_cnt2),
    .lost_clr_i         (lost_clr2)
  );

  int total = 0;
  int bad   = 0;
  int unsigned q[$];
  int unsigned q2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid && fulln) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut_unexpected_id: got %0d expected no transfer at %0t", data, $time);
      end else begin
        check("dut_id", 64'(data), 64'(q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid2 && fulln2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut2_unexpected_id: got %0d expected no transfer at %0t", data2, $time);
      end else begin
        check("dut2_id", 64'(data2), 64'(q2.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [31:0] v);
    events = v;
    tick();
    events = '0;
  endtask

  initial begin
    rst_n = 1'b0; events = '0; mask = '0; fulln = 1'b1; lost_clr = 1'b0;
    events2 = '0; fulln2 = 1'b1; lost_clr2 = 1'b0;
    idle(2);
    check("rst_valid", 64'(valid), 0);
    check("rst_data", 64'(data), 0);
    check("rst_pending", 64'(pending), 0);
    check("rst_lost_evt", 64'(lost_evt), 0);
    check("rst_lost_cnt", 64'(lost_cnt), 0);
    check("rst_valid2", 64'(valid2), 0);

    // Single event latency.
    rst_n = 1'b1;
    q.push_back(5);
    pulse(32'h1 << 5);
    check("lat_pending_t1", 64'(pending), 64'h20);
    check("lat_valid_t1", 64'(valid), 0);
    tick();
    check("lat_pending_t2", 64'(pending), 0);
    check("lat_valid_t2", 64'(valid), 1);
    check("lat_data_t2", 64'(data), 5);
    tick();
    check("lat_valid_t3", 64'(valid), 0);

    // Round-robin order and wrap, from a fresh pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.push_back(3); q.push_back(7); q.push_back(30);
    pulse((32'h1 << 3) | (32'h1 << 7) | (32'h1 << 30));
    idle(5);
    q.push_back(2);
    pulse(32'h1 << 2);
    idle(3);
    q.push_back(5); q.push_back(1);
    pulse((32'h1 << 1) | (32'h1 << 5));
    idle(4);

    // Backpressure hold, pending re-arm and a lost event.
    fulln = 1'b0;
    q.push_back(4);
    pulse(32'h1 << 4);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 64'(valid), 1);
      check("hold_data", 64'(data), 4);
      tick();
    end
    pulse(32'h1 << 4);
    check("rearm_pending", 64'(pending), 64'h10);
    check("rearm_no_loss", 64'(lost_evt), 0);
    pulse(32'h1 << 4);
    check("loss_evt", 64'(lost_evt), 1);
    check("loss_cnt", 64'(lost_cnt), 1);
    tick();
    check("loss_evt_pulse_end", 64'(lost_evt), 0);
    check("hold_data_after_loss", 64'(data), 4);
    q.push_back(4);
    fulln = 1'b1;
    idle(4);
    check("drain_pending", 64'(pending), 0);

    // Event arriving on the grant cycle re-arms without loss.
    q.push_back(9); q.push_back(9);
    events = 32'h1 << 9;
    idle(2);
    events = '0;
    idle(4);
    check("grant_rearm_cnt", 64'(lost_cnt), 1);

    // Masked source never pends; masking keeps an existing pending bit.
    mask = 32'h1 << 1;
    pulse(32'h1 << 1);
    check("mask_pending", 64'(pending), 0);
    idle(3);
    mask = '0;
    fulln = 1'b0;
    q.push_back(6); q.push_back(8);
    pulse((32'h1 << 6) | (32'h1 << 8));
    tick();
    mask = 32'h1 << 8;
    tick();
    check("mask_keeps_pending", 64'(pending), 64'h100);
    fulln = 1'b1;
    idle(3);
    mask = '0;

    // ID_BASE offset.
    q2.push_back(16);
    events2 = 32'h1;
    tick();
    events2 = '0;
    idle(3);

    // Saturating lost counter and clear-over-increment priority.
    fulln2 = 1'b0;
    q2.push_back(16); q2.push_back(16);
    events2 = 32'h1;
    idle(20);
    check("sat_cnt", 64'(lost_cnt2), 15);
    tick();
    check("sat_cnt_hold", 64'(lost_cnt2), 15);
    check("sat_evt", 64'(lost_evt2), 1);
    lost_clr2 = 1'b1;
    tick();
    lost_clr2 = 1'b0;
    check("clr_priority_cnt", 64'(lost_cnt2), 0);
    check("clr_priority_evt", 64'(lost_evt2), 1);
    events2 = '0;
    tick();
    check("clr_cnt_stays", 64'(lost_cnt2), 0);
    fulln2 = 1'b1;
    idle(4);

    // Reset mid-stream discards held output and pending events.
    fulln = 1'b0;
    pulse((32'h1 << 10) | (32'h1 << 11));
    tick();
    check("midrst_pre_valid", 64'(valid), 1);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 64'(valid), 0);
    check("midrst_pending", 64'(pending), 0);
    check("midrst_data", 64'(data), 0);
    check("midrst_lost_cnt", 64'(lost_cnt), 0);
    rst_n = 1'b1;
    fulln = 1'b1;
    idle(4);

    check("dut_queue_empty", 64'(q.size()), 0);
    check("dut2_queue_empty", 64'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
